// File: rtl/tristate_capture_8bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tristate_capture_8bit : captures a byte from a shared bus on a validated we_n strobe
// Revision: 1.0
// ---------------------------------------------------------------------------
module tristate_capture_8bit #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       T,
  input  logic [7:0] D,
  input  logic       we_n,
  output logic [7:0] O,
  output logic       valid,
  input  logic       ack,
  output logic       overrun,
  output logic       collision
);

  localparam logic [3:0] MIN_LOW_C = 4'(MIN_LOW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    ARMED = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0]      we_sync_q;
  logic [SYNC_STAGES-1:0]      live_q;
  logic [SYNC_STAGES-1:0][7:0] d_sync_q;
  logic                        prev_high_q;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0] hold_q, hold_d;
  logic [7:0] o_q, o_d;
  logic       valid_q, valid_d;
  logic       overrun_q, overrun_d;
  logic       collision_q, collision_d;
  logic       commit, coll_set;

  logic       ws;
  logic [7:0] ds;
  logic       live;

  assign ws   = we_sync_q[SYNC_STAGES-1];
  assign ds   = d_sync_q[SYNC_STAGES-1];
  assign live = live_q[SYNC_STAGES-1];

  // live_q marks when ws reflects a real pin sample rather than the reset value,
  // so a we_n held low across reset release is never mistaken for a new strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_sync_q   <= '1;
      live_q      <= '0;
      d_sync_q    <= '0;
      prev_high_q <= 1'b0;
    end else begin
      we_sync_q   <= {we_sync_q[SYNC_STAGES-2:0], we_n};
      live_q      <= {live_q[SYNC_STAGES-2:0], 1'b1};
      d_sync_q    <= {d_sync_q[SYNC_STAGES-2:0], D};
      prev_high_q <= live & ws;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    commit   = 1'b0;
    coll_set = 1'b0;
    cnt_inc  = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    case (state_q)
      IDLE: begin
        if (!ws && prev_high_q && !T) begin
          cnt_d   = 4'd1;
          hold_d  = ds;
          state_d = (MIN_LOW_C <= 4'd1) ? ARMED : LOW;
        end
      end
      LOW: begin
        if (T) begin
          state_d  = IDLE;
          coll_set = 1'b1;
        end else if (ws) begin
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_inc;
          hold_d = ds;
          if (cnt_inc >= MIN_LOW_C) state_d = ARMED;
        end
      end
      ARMED: begin
        if (T) begin
          state_d  = IDLE;
          coll_set = 1'b1;
        end else if (ws) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d  = cnt_inc;
          hold_d = ds;
        end
      end
      default: state_d = IDLE;
    endcase

    o_d         = commit ? hold_q : o_q;
    valid_d     = commit ? 1'b1 : ((ack && valid_q) ? 1'b0 : valid_q);
    overrun_d   = overrun_q | (commit & valid_q & ~ack);
    collision_d = collision_q | coll_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      hold_q      <= 8'h00;
      o_q         <= 8'h00;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      o_q         <= o_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      collision_q <= collision_d;
    end
  end

  assign O         = o_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign collision = collision_q;

endmodule
`default_nettype wire

// File: tb/tb_tristate_capture_8bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tristate_capture_8bit : directed scenarios plus random strobes vs a run-length model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tristate_capture_8bit;

  localparam int S  = 2;
  localparam int ML = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       T = 1'b0;
  logic [7:0] D = 8'h00;
  logic       we_n = 1'b1;
  logic [7:0] O;
  logic       valid;
  logic       ack = 1'b0;
  logic       overrun;
  logic       collision;

  int total = 0;
  int bad   = 0;

  tristate_capture_8bit #(.SYNC_STAGES(S), .MIN_LOW(ML)) dut (
    .clk(clk), .reset_n(reset_n), .T(T), .D(D), .we_n(we_n),
    .O(O), .valid(valid), .ack(ack), .overrun(overrun), .collision(collision)
  );

  always #5 clk = ~clk;

  // Model: the block sees each pin sample S edges late; a strobe is a run of low
  // samples begun right after a real high sample, committed if it reaches ML samples.
  typedef struct packed {
    logic       live;
    logic       w;
    logic [7:0] d;
  } samp_t;

  samp_t      pipe[$];
  logic [7:0] m_O, m_hold;
  logic       m_valid, m_ovr, m_coll, m_active, m_prev_high;
  int         m_len;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    repeat (S) pipe.push_front(samp_t'{live: 1'b0, w: 1'b1, d: 8'h00});
    m_O = 8'h00; m_hold = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_coll = 1'b0;
    m_active = 1'b0; m_prev_high = 1'b0; m_len = 0;
  endtask

  task automatic model_step(input logic w, input logic [7:0] d, input logic t, input logic a);
    samp_t obs;
    logic  commit;
    commit = 1'b0;
    obs = pipe.pop_back();
    pipe.push_front(samp_t'{live: 1'b1, w: w, d: d});
    if (m_active) begin
      if (t) begin
        m_coll = 1'b1;
        m_active = 1'b0;
      end else if (obs.w) begin
        commit = (m_len >= ML);
        m_active = 1'b0;
      end else begin
        m_len = (m_len < 15) ? m_len + 1 : 15;
        m_hold = obs.d;
      end
    end else if (!obs.w && m_prev_high && !t) begin
      m_active = 1'b1;
      m_len = 1;
      m_hold = obs.d;
    end
    m_prev_high = obs.live && obs.w;
    if (commit) begin
      if (m_valid && !a) m_ovr = 1'b1;
      m_O = m_hold;
      m_valid = 1'b1;
    end else if (a && m_valid) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next fall.
  task automatic cyc(input logic w, input logic [7:0] d, input logic t, input logic a);
    we_n = w; D = d; T = t; ack = a;
    @(posedge clk);
    model_step(w, d, t, a);
    @(negedge clk);
    check_val("O", {24'h0, O}, {24'h0, m_O});
    check_val("valid", {31'h0, valid}, {31'h0, m_valid});
    check_val("overrun", {31'h0, overrun}, {31'h0, m_ovr});
    check_val("collision", {31'h0, collision}, {31'h0, m_coll});
  endtask

  task automatic apply_reset(input logic w);
    we_n = w; T = 1'b0; ack = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_O", {24'h0, O}, 32'h0);
    check_val("rst_valid", {31'h0, valid}, 32'h0);
    check_val("rst_overrun", {31'h0, overrun}, 32'h0);
    check_val("rst_collision", {31'h0, collision}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic strobe(input logic [7:0] d, input int low, input logic ack_at_commit);
    for (int i = 0; i < low; i++) cyc(1'b0, d, 1'b0, 1'b0);
    for (int i = 1; i <= S + 2; i++) cyc(1'b1, d, 1'b0, ack_at_commit && (i == S + 1));
  endtask

  initial begin
    logic [7:0] rd;
    int         lo, hi;

    apply_reset(1'b1);
    for (int i = 0; i < S + 2; i++) cyc(1'b1, 8'h00, 1'b0, 1'b0);

    // Too-short strobe is a glitch
    strobe(8'hEE, 1, 1'b0);
    check_val("short_valid", {31'h0, valid}, 32'h0);
    check_val("short_O", {24'h0, O}, 32'h0);

    // Basic capture and rise-to-valid latency
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'hA5, 1'b0, 1'b0);
    for (int i = 1; i <= S + 1; i++) begin
      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      check_val("lat_valid", {31'h0, valid}, (i == S + 1) ? 32'h1 : 32'h0);
    end
    check_val("a5_O", {24'h0, O}, 32'hA5);
    check_val("a5_overrun", {31'h0, overrun}, 32'h0);
    check_val("a5_collision", {31'h0, collision}, 32'h0);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);
    check_val("a5_ack_valid", {31'h0, valid}, 32'h0);
    check_val("a5_hold_O", {24'h0, O}, 32'hA5);

    // Commit coincides with ack of the prior byte
    strobe(8'h11, 3, 1'b0);
    strobe(8'h5A, 3, 1'b1);
    check_val("simul_O", {24'h0, O}, 32'h5A);
    check_val("simul_valid", {31'h0, valid}, 32'h1);
    check_val("simul_overrun", {31'h0, overrun}, 32'h0);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);

    // Overrun, then ack clears valid but not the sticky flag
    strobe(8'h3C, 3, 1'b0);
    strobe(8'hFF, 3, 1'b0);
    check_val("ovr_O", {24'h0, O}, 32'hFF);
    check_val("ovr_flag", {31'h0, overrun}, 32'h1);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);
    check_val("ovr_ack_valid", {31'h0, valid}, 32'h0);
    check_val("ovr_sticky", {31'h0, overrun}, 32'h1);
    cyc(1'b1, 8'h00, 1'b0, 1'b1);

    // Driver takes the bus during an armed strobe
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h99, 1'b1, 1'b0);
    for (int i = 0; i < S + 2; i++) cyc(1'b1, 8'h99, 1'b1, 1'b0);
    check_val("coll_flag", {31'h0, collision}, 32'h1);
    check_val("coll_valid", {31'h0, valid}, 32'h0);
    check_val("coll_O", {24'h0, O}, 32'hFF);
    for (int i = 0; i < S + 2; i++) cyc(1'b1, 8'h00, 1'b0, 1'b0);
    strobe(8'h77, 3, 1'b0);
    check_val("after_coll_O", {24'h0, O}, 32'h77);
    check_val("after_coll_valid", {31'h0, valid}, 32'h1);

    // Reset mid-strobe; we_n still low at release must not capture
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h42, 1'b0, 1'b0);
    apply_reset(1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h42, 1'b0, 1'b0);
    for (int i = 0; i < S + 2; i++) cyc(1'b1, 8'h42, 1'b0, 1'b0);
    check_val("post_rst_valid", {31'h0, valid}, 32'h0);
    check_val("post_rst_O", {24'h0, O}, 32'h0);
    strobe(8'hC3, 3, 1'b0);
    check_val("post_rst_cap", {24'h0, O}, 32'hC3);

    // Random strobes, glitches, bus turnarounds and acks
    repeat (80) begin
      lo = $urandom_range(1, 5);
      hi = $urandom_range(1, S + 3);
      rd = 8'($urandom);
      for (int i = 0; i < lo; i++)
        cyc(1'b0, ($urandom_range(0, 3) == 0) ? 8'($urandom) : rd,
            ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)));
      for (int i = 0; i < hi; i++)
        cyc(1'b1, rd, ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
